info_ram_retire: RTL and testbench
==================================

Name: info_ram_retire

Overview:
- Consumer end of the pending-request info RAM: accepts tagged memory responses, uses the tag as the RAM slot index, and pulses the RAM read-out/release.
- Combines the stored request info/address with the returned data into a registered writeback packet for the register-file writeback stage.
- Sits between the memory response path and writeback, opposite the issue side that allocates slots and hands out the slot tag.

Parameters:
- TAG_W, 5, slot index width; RAM holds 2**TAG_W entries.
- INFO_W, 16, request info width: lane mask, warp id, dest reg, op bits.
- ADDR_W, 256, per-request address bundle width (all lanes).
- DATA_W, 256, per-request data bundle width (all lanes).
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- stall_i  in  1  global pipeline stall; blocks retire and RAM release.
- resp_valid_i  in  1  memory response valid.
- resp_tag_i  in  TAG_W  slot index returned with the response.
- resp_data_i  in  DATA_W  load data.
- resp_ready_o  out  1  FIFO not full.
- ram_write_i  in  1  issue side's RAM write this cycle (write/release conflict).
- ram_out_o  out  1  release pulse to the info RAM.
- ram_out_addr_o  out  TAG_W  slot to read/release.
- ram_info_i  in  INFO_W  async read data from the RAM at ram_out_addr_o.
- ram_addr_i  in  ADDR_W  async read address bundle.
- wb_valid_o  out  1  writeback packet valid.
- wb_ready_i  in  1  writeback accepts the packet.
- wb_info_o  out  INFO_W  registered info.
- wb_addr_o  out  ADDR_W  registered address.
- wb_data_o  out  DATA_W  registered response data.
- fifo_count_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: FIFO empty and fifo_count_o=0; resp_ready_o=1; ram_out_o=0; ram_out_addr_o=0; wb_valid_o=0; wb_info_o, wb_addr_o, wb_data_o all 0; FSM in IDLE. Reset in the middle of an operation drops FIFO contents and any pending packet.
- Response FIFO push: occurs when resp_valid_i and resp_ready_o are both high. It stores {tag, data}.
- resp_ready_o: equals (count != FIFO_DEPTH). It is registered-count based, so a pop in the same cycle does not raise ready.
- FSM state IDLE:
  - Fire condition: FIFO non-empty, ~stall_i, ~ram_write_i.
  - ram_out_o is combinational: 1 on fire. ram_out_addr_o is combinational: head tag.
  - On fire, the same cycle: capture ram_info_i, ram_addr_i and head data into the wb registers; pop the FIFO; set wb_valid_o; go to WB.
  - Retire latency: 1 cycle from FIFO head to wb_valid_o.
- FSM state WB:
  - Hold wb_valid_o and the packet stable until wb_ready_i.
  - On the handshake: if the fire condition holds in the same cycle, retire back-to-back and stay in WB (1 packet per cycle throughput). Otherwise clear wb_valid_o and go to IDLE.
  - wb_ready_i is honoured regardless of stall_i.
- Conflict rule: the RAM gives write priority over release. ram_out_o must never assert while ram_write_i=1 or stall_i=1; the retire waits.
- Simultaneous push and pop: count is unchanged. Push into a full FIFO is impossible (ready low). Pop from an empty FIFO never occurs.
- Pointers: wrap modulo FIFO_DEPTH. Count is width log2(FIFO_DEPTH)+1.
- Tags: no duplicate-tag or valid checking here; the RAM ignores release of an invalid slot.

Test Plan:
- Single response tag=5, data=0xA5..: cycle N push; N+1 ram_out_o=1, addr=5; N+2 wb_valid_o=1 with RAM info/addr of slot 5 and data 0xA5..; wb_ready_i=1 -> IDLE.
- Burst of 4 responses with tags 3,7,1,9 and wb_ready_i held 1: releases occur in order 3,7,1,9 on consecutive cycles; 4 consecutive wb packets.
- Fill: wb_ready_i=0, 5 responses: FIFO takes tag 1 (retired to wb) plus 4 more; resp_ready_o=0 and fifo_count_o=4; raise wb_ready_i -> ready rises the cycle after the first pop.
- Conflict: ram_write_i=1 for 3 cycles with a response queued: ram_out_o stays 0; it asserts the cycle ram_write_i drops.
- Stall: stall_i=1 with the FIFO non-empty and the wb packet accepted: no ram_out_o, packet registers unchanged; release proceeds after the stall clears.
- Reset asserted while wb_valid_o=1 with 2 entries queued: next cycle wb_valid_o=0, fifo_count_o=0, resp_ready_o=1, no ram_out_o.

Source files
------------

// File: rtl/info_ram_retire.sv
// Retire side of the pending-request info RAM: buffers tagged memory responses, releases
// the matching RAM slot and merges its info/address with the load data into a writeback packet.
module info_ram_retire #(
    parameter int TAG_W      = 5,
    parameter int INFO_W     = 16,
    parameter int ADDR_W     = 256,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall_i,
    input  logic                            resp_valid_i,
    input  logic [TAG_W-1:0]                resp_tag_i,
    input  logic [DATA_W-1:0]               resp_data_i,
    output logic                            resp_ready_o,
    input  logic                            ram_write_i,
    output logic                            ram_out_o,
    output logic [TAG_W-1:0]                ram_out_addr_o,
    input  logic [INFO_W-1:0]               ram_info_i,
    input  logic [ADDR_W-1:0]               ram_addr_i,
    output logic                            wb_valid_o,
    input  logic                            wb_ready_i,
    output logic [INFO_W-1:0]               wb_info_o,
    output logic [ADDR_W-1:0]               wb_addr_o,
    output logic [DATA_W-1:0]               wb_data_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WB} state_t;

    state_t state_reg, state_next;

    logic [TAG_W-1:0]  tag_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [INFO_W-1:0] wb_info_reg;
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;

    logic push, fire, fifo_empty;

    assign fifo_empty   = (count_reg == '0);
    assign resp_ready_o = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push         = resp_valid_i && resp_ready_o;
    // RAM write has priority over release; in WB a new retire needs the current packet taken.
    assign fire = !fifo_empty && !stall_i && !ram_write_i &&
                  ((state_reg == IDLE) || wb_ready_i);

    // FIFO storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg]  <= resp_tag_i;
            data_mem[wr_ptr_reg] <= resp_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_info_reg <= '0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else if (fire) begin
            wb_info_reg <= ram_info_i;
            wb_addr_reg <= ram_addr_i;
            wb_data_reg <= data_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fire) state_next = WB;
            WB:      if (wb_ready_i && !fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_out_o      = fire;
        ram_out_addr_o = fifo_empty ? '0 : tag_mem[rd_ptr_reg];
        wb_valid_o     = (state_reg == WB);
    end

    assign wb_info_o    = wb_info_reg;
    assign wb_addr_o    = wb_addr_reg;
    assign wb_data_o    = wb_data_reg;
    assign fifo_count_o = count_reg;
endmodule

// File: tb/tb_info_ram_retire.sv
// Scoreboard bench for info_ram_retire: a behavioural RAM and FIFO-order queues predict
// every release tag and every writeback packet.
module tb_info_ram_retire;
    localparam int TAG_W = 5, INFO_W = 16, ADDR_W = 256, DATA_W = 256, DEPTH = 4;

    logic clk = 1'b0;
    logic reset, stall_i, resp_valid_i, resp_ready_o, ram_write_i, ram_out_o;
    logic wb_valid_o, wb_ready_i;
    logic [TAG_W-1:0]  resp_tag_i, ram_out_addr_o;
    logic [DATA_W-1:0] resp_data_i, wb_data_o;
    logic [INFO_W-1:0] ram_info_i, wb_info_o;
    logic [ADDR_W-1:0] ram_addr_i, wb_addr_o;
    logic [2:0]        fifo_count_o;

    typedef struct packed {
        logic [INFO_W-1:0] info;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

    logic [INFO_W-1:0] info_mem [2**TAG_W];
    logic [ADDR_W-1:0] addr_mem [2**TAG_W];
    pkt_t             exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign ram_info_i = info_mem[ram_out_addr_o];
    assign ram_addr_i = addr_mem[ram_out_addr_o];

    info_ram_retire #(.TAG_W(TAG_W), .INFO_W(INFO_W), .ADDR_W(ADDR_W),
                      .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .resp_valid_i(resp_valid_i), .resp_tag_i(resp_tag_i), .resp_data_i(resp_data_i),
        .resp_ready_o(resp_ready_o), .ram_write_i(ram_write_i),
        .ram_out_o(ram_out_o), .ram_out_addr_o(ram_out_addr_o),
        .ram_info_i(ram_info_i), .ram_addr_i(ram_addr_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_info_o(wb_info_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .fifo_count_o(fifo_count_o)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Monitor: compare first, then record responses entering the FIFO at the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            tag_q.delete();
        end else begin
            if (ram_out_o) begin
                chk("release_while_blocked", {254'd0, stall_i, ram_write_i}, 256'd0);
                if (tag_q.size() == 0) begin
                    chk("release_unexpected", 256'd1, 256'd0);
                end else begin
                    chk("release_tag", 256'(ram_out_addr_o), 256'(tag_q[0]));
                    void'(tag_q.pop_front());
                end
            end
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 256'd1, 256'd0);
                end else begin
                    chk("wb_info", 256'(wb_info_o), 256'(exp_q[0].info));
                    chk("wb_addr", wb_addr_o, exp_q[0].addr);
                    chk("wb_data", wb_data_o, exp_q[0].data);
                    if (wb_ready_i) void'(exp_q.pop_front());
                end
            end
            if (resp_valid_i && resp_ready_o) begin
                exp_q.push_back('{info_mem[resp_tag_i], addr_mem[resp_tag_i], resp_data_i});
                tag_q.push_back(resp_tag_i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        resp_valid_i = 1'b1;
        resp_tag_i   = t;
        resp_data_i  = d;
        step();
        resp_valid_i = 1'b0;
    endtask

    initial begin
        logic [TAG_W-1:0] burst_tags [4];
        burst_tags = '{5'd3, 5'd7, 5'd1, 5'd9};
        for (int i = 0; i < 2**TAG_W; i++) begin
            info_mem[i] = 16'($urandom);
            addr_mem[i] = rand_data();
        end
        reset = 1'b1; stall_i = 1'b0; resp_valid_i = 1'b0; resp_tag_i = '0;
        resp_data_i = '0; ram_write_i = 1'b0; wb_ready_i = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_count", 256'(fifo_count_o), 256'd0);
        chk("reset_ready", 256'(resp_ready_o), 256'd1);
        chk("reset_ram_out", 256'(ram_out_o), 256'd0);
        chk("reset_ram_addr", 256'(ram_out_addr_o), 256'd0);
        chk("reset_wb_valid", 256'(wb_valid_o), 256'd0);
        chk("reset_wb_data", wb_data_o, 256'd0);

        // Single response: release one cycle after push, packet the cycle after that.
        wb_ready_i = 1'b1;
        send(5'd5, {32{8'hA5}});
        chk("single_ram_out", 256'(ram_out_o), 256'd1);
        chk("single_ram_addr", 256'(ram_out_addr_o), 256'd5);
        step();
        chk("single_wb_valid", 256'(wb_valid_o), 256'd1);
        step();
        chk("single_wb_idle", 256'(wb_valid_o), 256'd0);

        foreach (burst_tags[i]) send(burst_tags[i], rand_data());
        repeat (6) step();

        // Fill: first response sits in wb, four more fill the FIFO.
        wb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(5'(i + 10), rand_data());
        chk("fill_count", 256'(fifo_count_o), 256'd4);
        chk("fill_ready_low", 256'(resp_ready_o), 256'd0);
        wb_ready_i = 1'b1;
        chk("fill_ready_same_cycle", 256'(resp_ready_o), 256'd0);
        step();
        chk("fill_ready_rises", 256'(resp_ready_o), 256'd1);
        chk("fill_count_after_pop", 256'(fifo_count_o), 256'd3);
        repeat (6) step();

        ram_write_i = 1'b1;
        send(5'd20, rand_data());
        for (int i = 0; i < 2; i++) begin
            chk("conflict_hold", 256'(ram_out_o), 256'd0);
            step();
        end
        chk("conflict_hold", 256'(ram_out_o), 256'd0);
        ram_write_i = 1'b0;
        #1;
        chk("conflict_release", 256'(ram_out_o), 256'd1);
        repeat (3) step();

        stall_i = 1'b1;
        send(5'd21, rand_data());
        chk("stall_hold", 256'(ram_out_o), 256'd0);
        step();
        chk("stall_hold", 256'(ram_out_o), 256'd0);
        stall_i = 1'b0;
        #1;
        chk("stall_release", 256'(ram_out_o), 256'd1);
        repeat (3) step();

        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(5'(i + 24), rand_data());
        chk("pre_reset_wb_valid", 256'(wb_valid_o), 256'd1);
        chk("pre_reset_count", 256'(fifo_count_o), 256'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_wb_valid", 256'(wb_valid_o), 256'd0);
        chk("mid_reset_count", 256'(fifo_count_o), 256'd0);
        chk("mid_reset_ready", 256'(resp_ready_o), 256'd1);
        chk("mid_reset_ram_out", 256'(ram_out_o), 256'd0);
        step();

        for (int c = 0; c < 1500; c++) begin
            resp_valid_i = ($urandom_range(0, 1) == 1);
            resp_tag_i   = 5'($urandom);
            resp_data_i  = rand_data();
            stall_i      = ($urandom_range(0, 4) == 0);
            ram_write_i  = ($urandom_range(0, 4) == 0);
            wb_ready_i   = ($urandom_range(0, 9) < 6);
            step();
        end
        resp_valid_i = 1'b0; stall_i = 1'b0; ram_write_i = 1'b0; wb_ready_i = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
        step();
        chk("drain_packets_left", 256'(exp_q.size()), 256'd0);
        chk("drain_tags_left", 256'(tag_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
